axil_piece_regfile: RTL and testbench

//  Parametrised AXI4-Lite slave register file, successor to the fixed 4-register

---
 rtl/axil_pkg.sv | 25 ++
 rtl/axil_piece_regfile_if.sv | 63 ++++++
 rtl/axil_chan_buf.sv | 54 +++++
 rtl/axil_piece_regfile.sv | 190 +++++++++++++++++++
 tb/tb_axil_piece_regfile.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// ============================================================================
// Package : axil_pkg
// Shared AXI4-Lite response encodings and address-to-register index helper
// for the piece-controller register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

package axil_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  // Word index of a byte address; lsb is log2 of the bytes per data beat.
  function automatic int unsigned addr2idx(input logic [63:0] addr, input int unsigned lsb);
    logic [63:0] shifted;
    shifted = addr >> lsb;
    return shifted[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_piece_regfile_if.sv
// ============================================================================
// Interface : axil_piece_regfile_if
// AXI4-Lite bus bundle between the host (master) and the register file (slave).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface axil_piece_regfile_if
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();

  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  axi_resp_t               S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  axi_resp_t               S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

`default_nettype wire

// File: rtl/axil_chan_buf.sv
// ============================================================================
// Module : axil_chan_buf
// One-entry valid/ready capture register. READY is a flop computed from the
// next-cycle occupancy, so it never depends combinationally on the source.
// 'avail' exposes the entry in the same cycle it is being captured so the
// consumer can act on the handshake edge itself.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axil_chan_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             hold_next,   // consumer stays busy after this edge
  input  logic             clear,       // drop the captured entry
  output logic             avail,
  output logic [WIDTH-1:0] avail_data
);

  logic             r_full;
  logic             r_ready;
  logic [WIDTH-1:0] r_data;
  logic             hs;
  logic             full_next;

  assign hs         = in_valid && r_ready;
  assign full_next  = clear ? 1'b0 : (r_full || hs);
  assign in_ready   = r_ready;
  assign avail      = r_full || hs;
  assign avail_data = r_full ? r_data : in_data;

  // Occupancy, registered READY and captured payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_ready <= 1'b0;
      r_data  <= '0;
    end else begin
      r_full  <= full_next;
      r_ready <= !full_next && !hold_next;
      if (hs) begin
        r_data <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axil_piece_regfile.sv
// ============================================================================
// Module : axil_piece_regfile
// Parametrised AXI4-Lite slave register file with byte strobes, read-only
// status registers, SLVERR on out-of-range addresses and independent AW/W
// acceptance. All registers are exported flat along with write pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axil_piece_regfile
  import axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axil_piece_regfile_if.slave            s_axi,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int          STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned NREGS_U  = NUM_REGS;

  // ---------------- write path ----------------
  logic                       aw_avail;
  logic [ADDR_WIDTH-1:0]      aw_addr;
  logic                       aw_ready;
  logic                       w_avail;
  logic [DATA_WIDTH+STRB_W-1:0] w_payload;
  logic                       w_ready;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic [STRB_W-1:0]          wr_strb;
  logic                       commit;
  logic                       b_hs;
  logic                       bvalid_next;
  logic                       r_bvalid;
  axi_resp_t                  r_bresp;
  int unsigned                wr_idx;
  logic                       wr_in_range;
  logic [NUM_REGS-1:0]        wr_hit;
  logic [NUM_REGS-1:0]        r_wr_pulse;

  // ---------------- read path -----------------
  logic                       ar_hs;
  logic                       r_arready;
  logic                       rvalid_next;
  logic                       r_rvalid;
  logic [DATA_WIDTH-1:0]      r_rdata;
  axi_resp_t                  r_rresp;
  int unsigned                rd_idx;
  logic                       rd_in_range;
  logic [DATA_WIDTH-1:0]      rd_mux;
  logic [DATA_WIDTH-1:0]      reg_val [NUM_REGS];

  logic                       unused_prot;
  assign unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  axil_chan_buf #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .in_valid   (s_axi.S_AXI_AWVALID),
    .in_ready   (aw_ready),
    .in_data    (s_axi.S_AXI_AWADDR),
    .hold_next  (bvalid_next),
    .clear      (b_hs),
    .avail      (aw_avail),
    .avail_data (aw_addr)
  );

  axil_chan_buf #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_buf (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .in_valid   (s_axi.S_AXI_WVALID),
    .in_ready   (w_ready),
    .in_data    ({s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB}),
    .hold_next  (bvalid_next),
    .clear      (b_hs),
    .avail      (w_avail),
    .avail_data (w_payload)
  );

  assign {wr_data, wr_strb} = w_payload;

  // Commit on the edge where both address and data are (or become) present.
  assign commit      = aw_avail && w_avail && !r_bvalid;
  assign b_hs        = r_bvalid && s_axi.S_AXI_BREADY;
  assign bvalid_next = commit ? 1'b1 : (b_hs ? 1'b0 : r_bvalid);
  assign wr_idx      = addr2idx(64'(aw_addr), ADDR_LSB);
  assign wr_in_range = wr_idx < NREGS_U;

  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign wr_pulse_o          = r_wr_pulse;

  // Register array: RW slots are flops, RO slots pass status straight through.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    localparam int unsigned IDX = g;

    assign wr_hit[g] = commit && (wr_idx == IDX) && !RO_MASK[g];

    if (RO_MASK[g]) begin : g_ro
      assign reg_val[g] = status_i[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] r_q;

      // Byte-strobed update of one RW register on its commit.
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          r_q <= RESET_VAL;
        end else if (wr_hit[g]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) begin
              r_q[b*8 +: 8] <= wr_data[b*8 +: 8];
            end
          end
        end
      end

      assign reg_val[g] = r_q;
    end

    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = reg_val[g];
  end

  // Write response and the one-cycle commit pulse.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_bvalid   <= bvalid_next;
      r_wr_pulse <= wr_hit;
      if (commit) begin
        r_bresp <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Read address decode; out-of-range indices match nothing and yield zero.
  assign ar_hs       = s_axi.S_AXI_ARVALID && r_arready;
  assign rvalid_next = ar_hs ? 1'b1 : ((r_rvalid && s_axi.S_AXI_RREADY) ? 1'b0 : r_rvalid);
  assign rd_idx      = addr2idx(64'(s_axi.S_AXI_ARADDR), ADDR_LSB);
  assign rd_in_range = rd_idx < NREGS_U;

  // Read mux over current register contents (pre-edge values).
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NREGS_U; i++) begin
      if (rd_idx == i) begin
        rd_mux = reg_val[i];
      end
    end
  end

  // Read response; a read is served in one cycle so no AR entry is ever pending
  // and ARREADY only waits for the R channel to drain.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rvalid  <= rvalid_next;
      r_arready <= !rvalid_next;
      if (ar_hs) begin
        r_rdata <= rd_in_range ? rd_mux : '0;
        r_rresp <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;

endmodule

`default_nettype wire

// File: tb/tb_axil_piece_regfile.sv
// ============================================================================
// Module : tb_axil_piece_regfile
// Directed self-checking bench for axil_piece_regfile (32-bit, 16 regs,
// register 5 read-only, non-zero reset value).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axil_piece_regfile;

  localparam logic [31:0] RST_V = 32'h1234_5678;

  logic         clk;
  logic         rst_n;
  logic [511:0] status;
  logic [511:0] regs;
  logic [15:0]  pulse;

  int n_chk = 0;
  int n_err = 0;

  axil_piece_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  axil_piece_regfile #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .NUM_REGS   (16),
    .RO_MASK    (16'h0020),
    .RESET_VAL  (RST_V)
  ) dut (
    .ACLK       (clk),
    .ARESETN    (rst_n),
    .s_axi      (bus),
    .status_i   (status),
    .regs_o     (regs),
    .wr_pulse_o (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [15:0] pls);
    logic aw_done, w_done, aw_hs, w_hs;
    int   n;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      tick();
      if (aw_hs) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin bus.S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      chk("wr_accept_timeout", 64'(n), 64'(0));
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
    end
    pls = pulse;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 20) begin
      tick();
      n++;
    end
    if (!bus.S_AXI_BVALID) chk("bvalid_timeout", 64'(bus.S_AXI_BVALID), 64'(1));
    resp = bus.S_AXI_BRESP;
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
  endtask

  // Data is sampled after one stalled cycle with RREADY low.
  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 20) begin
      tick();
      n++;
    end
    if (!bus.S_AXI_ARREADY) chk("arready_timeout", 64'(bus.S_AXI_ARREADY), 64'(1));
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    if (!bus.S_AXI_RVALID) chk("rvalid_latency", 64'(bus.S_AXI_RVALID), 64'(1));
    tick();
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [15:0] pls;
    logic [31:0] rd;
    int          seen;

    rst_n  = 1'b0;
    status = '0;
    status[5*32 +: 32] = 32'h0000_5A5A;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // Reset held 200 ns
    #200;
    tick();
    chk("rst_readys", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
    chk("rst_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    chk("rst_resp_data", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, 36'h0);
    chk("rst_reg0", regs[31:0], RST_V);
    chk("rst_reg15", regs[15*32 +: 32], RST_V);
    chk("rst_pulse", pulse, 16'h0);
    rst_n = 1'b1;
    tick();
    chk("awready_first_edge", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);

    // Sequential RW writes and readback
    for (int i = 0; i < 4; i++) begin
      axi_write(8'(i * 4), 32'(i + 1), 4'hF, resp, pls);
      chk("seq_bresp", resp, 2'b00);
      chk("seq_pulse", pls, 16'(1 << i));
    end
    chk("pulse_cleared", pulse, 16'h0);
    for (int i = 0; i < 4; i++) begin
      axi_read(8'(i * 4), rd, resp);
      chk("seq_rdata", rd, 32'(i + 1));
      chk("seq_rresp", resp, 2'b00);
    end
    chk("regs_o_slice3", regs[3*32 +: 32], 32'h4);

    // Byte strobes
    axi_write(8'h00, 32'hAABB_CCDD, 4'hF, resp, pls);
    axi_write(8'h00, 32'h1122_3344, 4'b0101, resp, pls);
    axi_read(8'h00, rd, resp);
    chk("strobe_rdata", rd, 32'hAA22_CC44);

    // W first, AW three cycles later
    bus.S_AXI_WDATA  = 32'hCAFE_0003;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    chk("ord_wready_idle", bus.S_AXI_WREADY, 1'b1);
    tick();
    bus.S_AXI_WVALID = 1'b0;
    chk("ord_w_only", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID}, 3'b100);
    tick();
    tick();
    bus.S_AXI_AWADDR  = 8'h0C;
    bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    chk("ord_bvalid", bus.S_AXI_BVALID, 1'b1);
    chk("ord_pulse", pulse, 16'h0008);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ord_hold", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, |pulse}, 4'b0010);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    chk("ord_release", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3'b011);
    axi_read(8'h0F, rd, resp);
    chk("ord_rdata_lowbits", rd, 32'hCAFE_0003);

    // Read-only register and address decode
    axi_write(8'h14, 32'hFFFF_FFFF, 4'hF, resp, pls);
    chk("ro_bresp", resp, 2'b00);
    chk("ro_no_pulse", pls, 16'h0);
    axi_read(8'h14, rd, resp);
    chk("ro_rdata", rd, 32'h0000_5A5A);
    chk("ro_regs_o", regs[5*32 +: 32], 32'h0000_5A5A);
    status[5*32 +: 32] = 32'h0BAD_F00D;
    axi_read(8'h14, rd, resp);
    chk("ro_rdata_live", rd, 32'h0BAD_F00D);
    axi_write(8'h40, 32'h5555_5555, 4'hF, resp, pls);
    chk("oor_bresp", resp, 2'b10);
    chk("oor_no_pulse", pls, 16'h0);
    axi_read(8'h40, rd, resp);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_rresp", resp, 2'b10);

    // Read and commit to reg1 on the same edge
    bus.S_AXI_AWADDR = 8'h04; bus.S_AXI_WDATA = 32'h77; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = 8'h04;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    chk("haz_readys", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    chk("haz_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b11);
    chk("haz_old_rdata", bus.S_AXI_RDATA, 32'h2);
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    axi_read(8'h04, rd, resp);
    chk("haz_new_rdata", rd, 32'h77);

    // Reset while a write response is pending
    bus.S_AXI_AWADDR = 8'h00; bus.S_AXI_WDATA = 32'h99; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    chk("rstb_bvalid_pre", bus.S_AXI_BVALID, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstb_bvalid_async", bus.S_AXI_BVALID, 1'b0);
    chk("rstb_reg0", regs[31:0], RST_V);
    tick();
    rst_n = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.S_AXI_BVALID) seen++;
    end
    bus.S_AXI_BREADY = 1'b0;
    chk("rstb_no_late_b", 64'(seen), 64'(0));
    axi_read(8'h00, rd, resp);
    chk("rstb_reg0_read", rd, RST_V);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
